puf_challenge_sequencer: RTL and testbench

- Autonomous initiator for the 16-oscillator RO PUF core; replaces manual VIO driving of select/enable/reset.
- On a start pulse, walks NUM_BITS oscillator pairs derived from an 8-bit challenge.
- For each pair: clears and enables the core, times the measurement window, samples the comparison bit, shifts it into a response word.
- Presents the word to a consumer over a valid/ready handshake.

---
 rtl/puf_pkg.sv | 32 +++
 rtl/puf_challenge_sequencer_if.sv | 42 ++++
 rtl/puf_phase_timer.sv | 34 +++
 rtl/puf_challenge_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_puf_challenge_sequencer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/puf_pkg.sv
// Shared types and constants for the RO PUF challenge sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state enum, core geometry constants, small width helpers.
package puf_pkg;

  localparam int RO_COUNT = 16;  // oscillators in the RO PUF core
  localparam int SEL_W    = 4;   // width of one oscillator select
  localparam int CNT_W    = 12;  // width of the core's RO counters

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    RUN,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/puf_challenge_sequencer_if.sv
// Bundle of every non-clock signal between the sequencer, the RO PUF core and the response consumer.
// Latency: n/a (wires only).
// Backpressure: resp_valid/resp_ready carries the response handshake; start is a bare request pulse.
//
// Ports (master = sequencer side):
//   start, challenge          request from the host
//   busy                      sequencer activity flag
//   sel_a, sel_b, ro_enable,
//   ro_reset                  controls into the RO PUF core
//   puf_bit, cnt_a, cnt_b     results from the RO PUF core
//   resp_valid, resp_ready,
//   resp_data, resp_mask      response word towards the consumer
interface puf_challenge_sequencer_if #(
  parameter int NUM_BITS = 16
) ();

  logic                       start;
  logic [7:0]                 challenge;
  logic                       busy;
  logic [puf_pkg::SEL_W-1:0]  sel_a;
  logic [puf_pkg::SEL_W-1:0]  sel_b;
  logic                       ro_enable;
  logic                       ro_reset;
  logic                       puf_bit;
  logic [puf_pkg::CNT_W-1:0]  cnt_a;
  logic [puf_pkg::CNT_W-1:0]  cnt_b;
  logic                       resp_valid;
  logic                       resp_ready;
  logic [NUM_BITS-1:0]        resp_data;
  logic [NUM_BITS-1:0]        resp_mask;

  modport master (
    input  start, challenge, puf_bit, cnt_a, cnt_b, resp_ready,
    output busy, sel_a, sel_b, ro_enable, ro_reset, resp_valid, resp_data, resp_mask
  );

  modport slave (
    output start, challenge, puf_bit, cnt_a, cnt_b, resp_ready,
    input  busy, sel_a, sel_b, ro_enable, ro_reset, resp_valid, resp_data, resp_mask
  );

endinterface

// File: rtl/puf_phase_timer.sv
// Loadable down-counter timing the CLR, RUN and SETTLE phases of the sequencer.
// Latency: done asserts load_val cycles after the load cycle (load_val=N-1 gives an N-cycle phase).
// Backpressure: none; load always wins over counting.
//
// Ports:
//   clock, reset   clock and asynchronous active-high reset
//   load           reload the counter with load_val this cycle
//   load_val       value loaded on load
//   done           counter has reached zero (terminal flag)
module puf_phase_timer #(
  parameter int W = 13
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Autonomous RO PUF initiator: walks NUM_BITS oscillator pairs from an 8-bit challenge and returns a response word.
// Latency: 1 + NUM_BITS*(RST_CYCLES+WINDOW_CYCLES+SETTLE_CYCLES+1) cycles from the start cycle to resp_valid.
// Backpressure: holds the word in DONE until resp_ready; start is ignored outside IDLE.
//
// Ports:
//   clock, reset   system clock, asynchronous active-high reset
//   bus (master)   start/challenge in, busy out, core controls out (sel_a, sel_b, ro_enable, ro_reset),
//                  core results in (puf_bit, cnt_a, cnt_b), response handshake out (resp_*)
// Optional build macro: PUF_MARGIN_CHECK_EN -- flags bits whose counter difference is below MARGIN in resp_mask.
module puf_challenge_sequencer
  import puf_pkg::*;
#(
  parameter int NUM_BITS      = 16,
  parameter int RST_CYCLES    = 4,
  parameter int WINDOW_CYCLES = 4200,
  parameter int SETTLE_CYCLES = 8,
  parameter int MARGIN        = 16
) (
  input logic clock,
  input logic reset,
  puf_challenge_sequencer_if.master bus
);

  localparam int MAX_PHASE = max3(RST_CYCLES, WINDOW_CYCLES, SETTLE_CYCLES);
  localparam int TMR_W     = cnt_width(MAX_PHASE);
  localparam int IDX_W     = cnt_width(NUM_BITS);

  localparam logic [TMR_W-1:0] RST_LD    = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] WINDOW_LD = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BITS - 1);

  state_e               state_q;
  state_e               state_n;
  logic [SEL_W-1:0]     base_q;
  logic [SEL_W-1:0]     stride_q;
  logic [IDX_W-1:0]     idx_q;
  logic [NUM_BITS-1:0]  data_q;

  logic                 start_acc;
  logic                 tmr_load;
  logic [TMR_W-1:0]     tmr_val;
  logic                 tmr_done;

  logic                 busy;
  logic                 ro_enable;
  logic                 ro_reset;
  logic                 resp_valid;
  logic [SEL_W-1:0]     sel_a;
  logic [SEL_W-1:0]     sel_b;

  assign start_acc = (state_q == IDLE) && bus.start;

  // Selects wrap modulo RO_COUNT through plain 4-bit truncating adds.
  assign sel_a = base_q + SEL_W'(idx_q);
  assign sel_b = sel_a + stride_q;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    busy       = 1'b1;
    ro_reset   = 1'b1;
    ro_enable  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (bus.start) state_n = CLR;
      end
      CLR: begin
        if (tmr_done) state_n = RUN;
      end
      RUN: begin
        ro_reset  = 1'b0;
        ro_enable = 1'b1;
        if (tmr_done) state_n = SETTLE;
      end
      SETTLE: begin
        ro_reset = 1'b0;
        if (tmr_done) state_n = SAMPLE;
      end
      SAMPLE: begin
        ro_reset = 1'b0;
        state_n  = (idx_q == LAST_IDX) ? DONE : CLR;
      end
      DONE: begin
        resp_valid = 1'b1;
        if (bus.resp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // The single timer reloads on every state change with the length of the phase being entered.
  always_comb begin
    tmr_load = (state_n != state_q);
    tmr_val  = '0;
    case (state_n)
      CLR:     tmr_val = RST_LD;
      RUN:     tmr_val = WINDOW_LD;
      SETTLE:  tmr_val = SETTLE_LD;
      default: tmr_val = '0;
    endcase
  end

  puf_phase_timer #(
    .W (TMR_W)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // ---------------------------------------------------------------------------
  // Challenge capture, pair index and response accumulation
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      base_q   <= '0;
      stride_q <= '0;
      idx_q    <= '0;
      data_q   <= '0;
    end else if (start_acc) begin
      base_q   <= bus.challenge[3:0];
      // A zero stride would pair an oscillator with itself.
      stride_q <= (bus.challenge[7:4] == 4'd0) ? 4'd1 : bus.challenge[7:4];
      idx_q    <= '0;
      data_q   <= '0;
    end else if (state_q == SAMPLE) begin
      data_q[idx_q] <= bus.puf_bit;
      if (idx_q != LAST_IDX) idx_q <= idx_q + IDX_W'(1);
    end
  end

`ifdef PUF_MARGIN_CHECK_EN
  logic [CNT_W:0]      diff_mag;
  logic                unstable;
  logic [NUM_BITS-1:0] mask_q;

  always_comb begin
    if (bus.cnt_a >= bus.cnt_b) begin
      diff_mag = {1'b0, bus.cnt_a} - {1'b0, bus.cnt_b};
    end else begin
      diff_mag = {1'b0, bus.cnt_b} - {1'b0, bus.cnt_a};
    end
    unstable = (diff_mag < (CNT_W+1)'(MARGIN));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
    end else if (start_acc) begin
      mask_q <= '0;
    end else if (state_q == SAMPLE) begin
      mask_q[idx_q] <= unstable;
    end
  end

  assign bus.resp_mask = mask_q;
`else
  assign bus.resp_mask = '0;
`endif

  assign bus.busy       = busy;
  assign bus.sel_a      = sel_a;
  assign bus.sel_b      = sel_b;
  assign bus.ro_enable  = ro_enable;
  assign bus.ro_reset   = ro_reset;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_data  = data_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Self-checking bench for puf_challenge_sequencer with NUM_BITS=4 and a behavioural RO PUF core.
// Latency: n/a (testbench).
// Backpressure: drives resp_ready both held-low and always-high.
module tb_puf_challenge_sequencer;

  localparam int NB  = 4;
  localparam int RC  = 4;
  localparam int WC  = 4200;
  localparam int SC  = 8;
  localparam int LAT = 1 + NB * (RC + WC + SC + 1);

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  puf_challenge_sequencer_if #(.NUM_BITS(NB)) bus ();

  puf_challenge_sequencer #(
    .NUM_BITS      (NB),
    .RST_CYCLES    (RC),
    .WINDOW_CYCLES (WC),
    .SETTLE_CYCLES (SC),
    .MARGIN        (16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Core model: the comparison bit is 1 when sel_a is even.
  assign bus.puf_bit = ~bus.sel_a[0];

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0]    sel_exp_q[$];
  logic [NB-1:0] data_exp_q[$];
  logic [NB-1:0] mask_exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_mask_bit(input logic [11:0] a, input logic [11:0] b);
`ifdef PUF_MARGIN_CHECK_EN
    int d;
    d = (int'(a) > int'(b)) ? int'(a) - int'(b) : int'(b) - int'(a);
    return (d < 16);
`else
    return 1'b0;
`endif
  endfunction

  task automatic push_expect(input logic [7:0] ch);
    logic [3:0]    b, s, sa, sb;
    logic [NB-1:0] d, m;
    b = ch[3:0];
    s = (ch[7:4] == 4'd0) ? 4'd1 : ch[7:4];
    d = '0;
    m = '0;
    for (int i = 0; i < NB; i++) begin
      sa = b + 4'(i);
      sb = sa + s;
      sel_exp_q.push_back({sa, sb});
      d[i] = ~sa[0];
      m[i] = exp_mask_bit(bus.cnt_a, bus.cnt_b);
    end
    data_exp_q.push_back(d);
    mask_exp_q.push_back(m);
  endtask

  task automatic start_and_wait(input logic [7:0] ch, input string tag);
    int cycles;
    @(posedge clock); #1;
    bus.challenge = ch;
    bus.start     = 1'b1;
    push_expect(ch);
    @(posedge clock); #1;
    bus.start = 1'b0;
    cycles    = 1;
    while (!bus.resp_valid && cycles < LAT + 50) begin
      @(posedge clock); #1;
      cycles++;
    end
    check({tag, "_latency"}, cycles, LAT);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pair selects, phase lengths and the response handshake
  // ---------------------------------------------------------------------------
  int         en_len = 0;
  int         clr_len = 0;
  int         rst_in_run = 0;
  logic       prev_en = 1'b0;
  logic       prev_rst = 1'b1;
  logic [7:0] sel_e;
  logic [NB-1:0] data_e, mask_e;

  always @(negedge clock) begin
    if (reset) begin
      en_len     = 0;
      clr_len    = 0;
      rst_in_run = 0;
      prev_en    = 1'b0;
      prev_rst   = 1'b1;
    end else begin
      if (bus.ro_enable && !prev_en) begin
        if (sel_exp_q.size() == 0) begin
          check("sel_unexpected", sel_exp_q.size(), 1);
        end else begin
          sel_e = sel_exp_q.pop_front();
          check("sel_a", bus.sel_a, sel_e[7:4]);
          check("sel_b", bus.sel_b, sel_e[3:0]);
        end
      end
      if (bus.ro_enable) begin
        en_len++;
        if (bus.ro_reset) rst_in_run++;
      end else if (prev_en) begin
        check("run_len", en_len, WC);
        check("rst_in_run", rst_in_run, 0);
        en_len     = 0;
        rst_in_run = 0;
      end
      if (bus.busy && bus.ro_reset) begin
        clr_len++;
      end else begin
        if (bus.busy && prev_rst) check("clr_len", clr_len, RC);
        clr_len = 0;
      end
      if (bus.resp_valid && bus.resp_ready) begin
        if (data_exp_q.size() == 0) begin
          check("resp_unexpected", data_exp_q.size(), 1);
        end else begin
          data_e = data_exp_q.pop_front();
          mask_e = mask_exp_q.pop_front();
          check("resp_data", bus.resp_data, data_e);
          check("resp_mask", bus.resp_mask, mask_e);
        end
      end
      prev_en  = bus.ro_enable;
      prev_rst = bus.ro_reset;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [NB-1:0] held;
    int            bad;
    int            rises;
    int            cyc;
    logic          pe;

    bus.start      = 1'b0;
    bus.challenge  = 8'h00;
    bus.cnt_a      = 12'd0;
    bus.cnt_b      = 12'd0;
    bus.resp_ready = 1'b0;

    #1 reset = 1'b1;
    #2;
    check("rst_busy",       bus.busy,       0);
    check("rst_ro_reset",   bus.ro_reset,   1);
    check("rst_ro_enable",  bus.ro_enable,  0);
    check("rst_sel_a",      bus.sel_a,      0);
    check("rst_sel_b",      bus.sel_b,      0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_data",  bus.resp_data,  0);
    check("rst_resp_mask",  bus.resp_mask,  0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Challenge 0x21 with the consumer stalling in DONE and a stray start.
    bus.cnt_a = 12'd100;
    bus.cnt_b = 12'd90;
    start_and_wait(8'h21, "c21");
    held = bus.resp_data;
    bad  = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clock); #1;
      bus.challenge = 8'h77;
      bus.start     = (c == 50);
      if (bus.resp_data !== held || bus.resp_valid !== 1'b1) bad++;
    end
    bus.start = 1'b0;
    check("done_stable", bad, 0);
    check("done_data", held, 4'b1010);
    check("done_busy", bus.busy, 1);
    bus.resp_ready = 1'b1;
    @(posedge clock); #1;
    check("c21_valid_drop", bus.resp_valid, 0);
    check("c21_idle", bus.busy, 0);
    bus.resp_ready = 1'b0;
    check("c21_sel_left", sel_exp_q.size(), 0);

    // Challenge 0x0F: stride forced to 1, wrap from 15 to 0; ready held high throughout.
    bus.cnt_a      = 12'd200;
    bus.cnt_b      = 12'd100;
    bus.resp_ready = 1'b1;
    start_and_wait(8'h0F, "c0f");
    @(posedge clock); #1;
    check("c0f_valid_drop", bus.resp_valid, 0);
    check("c0f_idle", bus.busy, 0);
    bus.resp_ready = 1'b0;

    // Reset during the RUN phase of pair 2, then a fresh challenge.
    bus.cnt_a = 12'd100;
    bus.cnt_b = 12'd90;
    @(posedge clock); #1;
    bus.challenge = 8'h53;
    bus.start     = 1'b1;
    push_expect(8'h53);
    @(posedge clock); #1;
    bus.start = 1'b0;
    rises = 0;
    cyc   = 0;
    pe    = 1'b0;
    while (rises < 3 && cyc < 20000) begin
      @(posedge clock); #1;
      if (bus.ro_enable && !pe) rises++;
      pe = bus.ro_enable;
      cyc++;
    end
    check("reach_pair2", rises, 3);
    repeat (100) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("arst_ro_reset",  bus.ro_reset,  1);
    check("arst_ro_enable", bus.ro_enable, 0);
    check("arst_busy",      bus.busy,      0);
    check("arst_resp_data", bus.resp_data, 0);
    sel_exp_q.delete();
    data_exp_q.delete();
    mask_exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    start_and_wait(8'h54, "c54");
    check("c54_data", bus.resp_data, 4'b0101);
    bus.resp_ready = 1'b1;
    @(posedge clock); #1;
    check("c54_valid_drop", bus.resp_valid, 0);
    bus.resp_ready = 1'b0;

    check("sel_q_left",  sel_exp_q.size(),  0);
    check("resp_q_left", data_exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
